difftest_step_gen: RTL and testbench

DUT-side producer of the `difftest_step` count consumed by the simulation top each cycle. It sits inside `SimTop` between the difftest capture buffer and the `difftest_step` output port, batching committed snapshot cycles and reporting them as one nonzero step value. The top then calls `simv_nstep` with that value, or forwards it through the Palladium gfifo. The block provides batching, idle-timeout and flush release, downstream backpressure, and a running total for debug.

---
 rtl/difftest_step_gen.sv | 87 ++++++++
 tb/tb_difftest_step_gen.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/difftest_step_gen.sv
// Batches committed difftest snapshots into one nonzero step count per release,
// with full-batch, idle-timeout and flush release plus downstream backpressure.
module difftest_step_gen #(
    parameter int unsigned STEP_WIDTH = 8,
    parameter int unsigned BATCH_SIZE = 4,
    parameter int unsigned TIMEOUT    = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_flush,
    input  logic                  step_ready,
    output logic [STEP_WIDTH-1:0] difftest_step,
    output logic [63:0]           step_total
);

    localparam int unsigned PEND_W  = $clog2(BATCH_SIZE + 1);
    localparam int unsigned IDLE_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned TOTAL_W = 64;

    logic [PEND_W-1:0]     pending_q,    pending_d;
    logic [IDLE_W-1:0]     idle_cnt_q,   idle_cnt_d;
    logic                  flush_pend_q, flush_pend_d;
    logic [STEP_WIDTH-1:0] step_q,       step_d;
    logic [TOTAL_W-1:0]    total_q,      total_d;

    logic accept_c;
    logic fire_c;
    logic full_c;
    logic timed_out_c;

    assign full_c      = (pending_q == PEND_W'(BATCH_SIZE));
    assign timed_out_c = (idle_cnt_q >= IDLE_W'(TIMEOUT));
    assign in_ready    = ~full_c;

    // Next-state: a release takes priority; an accept on the release edge starts the next batch.
    always_comb begin
        pending_d    = pending_q;
        idle_cnt_d   = idle_cnt_q;
        flush_pend_d = flush_pend_q;
        step_d       = '0;
        total_d      = total_q;

        accept_c = enable & in_valid & ~full_c;
        fire_c   = enable & step_ready & (pending_q != '0)
                 & (full_c | timed_out_c | flush_pend_q);

        if (fire_c) begin
            step_d       = STEP_WIDTH'(pending_q);
            total_d      = total_q + TOTAL_W'(pending_q);
            pending_d    = accept_c ? PEND_W'(1) : '0;
            idle_cnt_d   = '0;
            flush_pend_d = in_flush & accept_c;
        end else if (enable) begin
            pending_d = pending_q + PEND_W'(accept_c);
            if (accept_c || (pending_q == '0)) begin
                idle_cnt_d = '0;
            end else if (!timed_out_c) begin
                idle_cnt_d = idle_cnt_q + IDLE_W'(1);
            end
            flush_pend_d = flush_pend_q | (in_flush & ((pending_q != '0) | accept_c));
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pending_q    <= '0;
            idle_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
            step_q       <= '0;
            total_q      <= '0;
        end else begin
            pending_q    <= pending_d;
            idle_cnt_q   <= idle_cnt_d;
            flush_pend_q <= flush_pend_d;
            step_q       <= step_d;
            total_q      <= total_d;
        end
    end

    assign difftest_step = step_q;
    assign step_total    = total_q;

endmodule

// File: tb/tb_difftest_step_gen.sv
// Directed self-checking bench for difftest_step_gen with default parameters.
module tb_difftest_step_gen;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        in_valid;
    logic        in_ready;
    logic        in_flush;
    logic        step_ready;
    logic [7:0]  difftest_step;
    logic [63:0] step_total;

    int n_checks = 0;
    int n_pass   = 0;

    difftest_step_gen #(.STEP_WIDTH(8), .BATCH_SIZE(4), .TIMEOUT(8)) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_flush      (in_flush),
        .step_ready    (step_ready),
        .difftest_step (difftest_step),
        .step_total    (step_total)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    initial begin
        int pend;
        int acc_cnt;
        int steps;
        logic [7:0] exp_step;

        reset = 1'b0; enable = 1'b0; in_valid = 1'b0; in_flush = 1'b0; step_ready = 1'b0;
        tick(); tick();
        chk("reset_step", 64'(difftest_step), 64'd0);
        chk("reset_total", step_total, 64'd0);
        chk("reset_ready", 64'(in_ready), 64'd1);

        // Full batch of 4
        reset = 1'b1; enable = 1'b1; step_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("full_no_early", 64'(difftest_step), 64'd0);
        end
        in_valid = 1'b0;
        chk("full_ready_low", 64'(in_ready), 64'd0);
        tick();
        chk("full_step", 64'(difftest_step), 64'd4);
        chk("full_total", step_total, 64'd4);
        chk("full_ready_back", 64'(in_ready), 64'd1);
        tick();
        chk("full_one_cycle", 64'(difftest_step), 64'd0);

        // Timeout release of a partial batch of 3
        in_valid = 1'b1;
        tick(); tick(); tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("tmo_no_early", 64'(difftest_step), 64'd0);
        end
        tick();
        chk("tmo_step", 64'(difftest_step), 64'd3);
        chk("tmo_total", step_total, 64'd7);
        tick();
        chk("tmo_one_cycle", 64'(difftest_step), 64'd0);

        // Flush release of 2, then a flush with nothing pending
        in_valid = 1'b1;
        tick(); tick();
        in_valid = 1'b0; in_flush = 1'b1;
        tick();
        in_flush = 1'b0;
        chk("flush_wait", 64'(difftest_step), 64'd0);
        tick();
        chk("flush_step", 64'(difftest_step), 64'd2);
        chk("flush_total", step_total, 64'd9);
        in_flush = 1'b1;
        tick();
        in_flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("flush_empty", 64'(difftest_step), 64'd0);
        end
        chk("flush_empty_total", step_total, 64'd9);

        // Backpressure: batch held while step_ready is low
        step_ready = 1'b0; in_valid = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("bp_ready", 64'(in_ready), (i < 4) ? 64'd1 : 64'd0);
            chk("bp_no_step", 64'(difftest_step), 64'd0);
        end
        in_valid = 1'b0; step_ready = 1'b1;
        tick();
        chk("bp_step", 64'(difftest_step), 64'd4);
        chk("bp_ready_back", 64'(in_ready), 64'd1);
        chk("bp_total", step_total, 64'd13);

        // Continuous stream until 40 snapshots are accepted
        pend = 0; acc_cnt = 0; steps = 0;
        for (int i = 0; i < 100 && acc_cnt < 40; i++) begin
            chk("stream_ready", 64'(in_ready), (pend != 4) ? 64'd1 : 64'd0);
            in_valid = 1'b1;
            tick();
            if (pend == 4) begin
                exp_step = 8'd4; pend = 0; steps++;
            end else begin
                exp_step = 8'd0; pend++; acc_cnt++;
            end
            chk("stream_step", 64'(difftest_step), 64'(exp_step));
        end
        in_valid = 1'b0;
        tick();
        chk("stream_last_step", 64'(difftest_step), 64'd4);
        if (difftest_step == 8'd4) steps++;
        chk("stream_accepts", 64'(acc_cnt), 64'd40);
        chk("stream_steps", 64'(steps), 64'd10);
        chk("stream_total", step_total, 64'd53);

        // Reset mid-batch discards pending snapshots
        in_valid = 1'b1;
        tick(); tick(); tick();
        in_valid = 1'b0; reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("rst_pending", 64'(dut.pending_q), 64'd0);
        chk("rst_idle", 64'(dut.idle_cnt_q), 64'd0);
        chk("rst_total", step_total, 64'd0);
        chk("rst_step", 64'(difftest_step), 64'd0);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("rst_no_release", 64'(difftest_step), 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
